// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared FSM encoding, default address width and offset arithmetic
package load_store_unit_pkg;
    localparam int DEFAULT_WORD_INDEX_BITS = 8;

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} lsuState_t;

    function automatic logic [31:0] offsetAddr(input logic [31:0] base, input logic [31:0] offset, input logic upDown);
        return upDown ? base + offset : base - offset;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-side request/response and dataMemory port of the load/store unit
interface load_store_unit_if;
    logic        start;
    logic        isLoad;
    logic        isByte;
    logic        preIndex;
    logic        upDown;
    logic        writeBack;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic [31:0] loadData;
    logic [31:0] wbAddr;
    logic        wbEn;
    logic        misaligned;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic        memoryEnable;
    logic        readNotWrite;

    modport master (
        output start, isLoad, isByte, preIndex, upDown, writeBack, base, offset, storeData, memDataOut,
        input  busy, done, loadData, wbAddr, wbEn, misaligned, memAddr, memDataIn, memoryEnable, readNotWrite
    );

    modport slave (
        input  start, isLoad, isByte, preIndex, upDown, writeBack, base, offset, storeData, memDataOut,
        output busy, done, loadData, wbAddr, wbEn, misaligned, memAddr, memDataIn, memoryEnable, readNotWrite
    );
endinterface

// File: rtl/load_store_unit_byte_lane_merge.sv
// load_store_unit_byte_lane_merge: little-endian byte extract (zero-extended) and byte insert on a 32-bit word
module load_store_unit_byte_lane_merge (
    input  logic [31:0] word,
    input  logic [7:0]  byteIn,
    input  logic [1:0]  lane,
    output logic [31:0] byteOut,
    output logic [31:0] mergedWord
);
    always_comb begin
        byteOut = {24'b0, word[{lane, 3'b000} +: 8]};
        mergedWord = word;
        mergedWord[{lane, 3'b000} +: 8] = byteIn;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: LDR/STR/LDRB/STRB address generation and sequencing of a registered word-indexed dataMemory
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WORD_INDEX_BITS = DEFAULT_WORD_INDEX_BITS
) (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);
    lsuState_t state, nextState;
    logic isLoadR, isByteR, wbEnR, misalignedR;
    logic [1:0] laneR;
    logic [WORD_INDEX_BITS-1:0] wordIdxR;
    logic [31:0] wordR, wbAddrR, loadDataR, sum, accAddr, byteOut, mergedWord;
    logic accept, unusedAddrBits;

    assign sum = offsetAddr(bus.base, bus.offset, bus.upDown);
    assign accAddr = bus.preIndex ? sum : bus.base;
    assign unusedAddrBits = ^accAddr[31:WORD_INDEX_BITS+2];
    assign accept = state == IDLE && bus.start;

    // STRB inserts its byte into the word read back in CAPTURE; wordR then holds the write data
    load_store_unit_byte_lane_merge laneMerge (
        .word(bus.memDataOut),
        .byteIn(wordR[7:0]),
        .lane(laneR),
        .byteOut(byteOut),
        .mergedWord(mergedWord)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.start ? ((bus.isLoad || bus.isByte) ? READ : WRITE) : IDLE;
            READ:    nextState = CAPTURE;
            CAPTURE: nextState = isLoadR ? DONE : WRITE;
            WRITE:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            isLoadR <= 1'b0;
            isByteR <= 1'b0;
            wbEnR <= 1'b0;
            misalignedR <= 1'b0;
            laneR <= '0;
            wordIdxR <= '0;
            wordR <= '0;
            wbAddrR <= '0;
            loadDataR <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                isLoadR <= bus.isLoad;
                isByteR <= bus.isByte;
                wbEnR <= bus.writeBack | ~bus.preIndex;
                misalignedR <= ~bus.isByte & (accAddr[1:0] != 2'b00);
                laneR <= accAddr[1:0];
                wordIdxR <= accAddr[WORD_INDEX_BITS+1:2];
                wordR <= bus.storeData;
                wbAddrR <= sum;
            end
            if (state == CAPTURE && isLoadR)
                loadDataR <= isByteR ? byteOut : bus.memDataOut;
            if (state == CAPTURE && !isLoadR)
                wordR <= mergedWord;
        end
    end

    // Reset gates the memory strobes combinationally so an aborted write never lands
    assign bus.memoryEnable = ~reset & (state == READ || state == WRITE);
    assign bus.readNotWrite = reset | (state != WRITE);
    assign bus.memAddr = 32'(wordIdxR);
    assign bus.memDataIn = wordR;
    assign bus.busy = ~reset & (state == READ || state == CAPTURE || state == WRITE);
    assign bus.done = ~reset & (state == DONE);
    assign bus.loadData = loadDataR;
    assign bus.wbAddr = wbAddrR;
    assign bus.wbEn = bus.done & wbEnR;
    assign bus.misaligned = bus.done & misalignedR;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a registered dataMemory model and a reference memory
module tb_load_store_unit;
    typedef struct {
        logic [31:0] loadData;
        logic [31:0] wbAddr;
        logic        wbEn;
        logic        mis;
        int          lat;
    } expect_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clearMem = 1'b1;
    logic [31:0] mem [256];
    logic [31:0] refMem [256];
    logic [31:0] lastLoad;
    logic [23:0] unusedMemAddrHi;
    expect_t sb[$];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

    assign unusedMemAddrHi = bus.memAddr[31:8];

    always_ff @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            bus.memDataOut <= '0;
        end else if (bus.memoryEnable) begin
            if (bus.readNotWrite) bus.memDataOut <= mem[bus.memAddr[7:0]];
            else mem[bus.memAddr[7:0]] <= bus.memDataIn;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) $display("FAIL %s: got %h expected %h", tag, actual, expected);
        else passed++;
    endtask

    task automatic drive(input logic ld, input logic bt, input logic p, input logic u, input logic w,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd);
        bus.isLoad = ld;
        bus.isByte = bt;
        bus.preIndex = p;
        bus.upDown = u;
        bus.writeBack = w;
        bus.base = b;
        bus.offset = o;
        bus.storeData = sd;
    endtask

    task automatic request(input logic ld, input logic bt, input logic p, input logic u, input logic w,
                           input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd, input logic poke);
        expect_t e;
        logic [31:0] s, a, wd;
        logic [4:0] sh;
        int lat;
        s = u ? b + o : b - o;
        a = p ? s : b;
        sh = {a[1:0], 3'b000};
        wd = refMem[a[9:2]];
        if (ld) lastLoad = bt ? (wd >> sh) & 32'hFF : wd;
        else if (bt) refMem[a[9:2]] = (wd & ~(32'hFF << sh)) | ({24'b0, sd[7:0]} << sh);
        else refMem[a[9:2]] = sd;
        e.loadData = lastLoad;
        e.wbAddr = s;
        e.wbEn = w | ~p;
        e.mis = ~bt & (a[1:0] != 2'b00);
        e.lat = ld ? 3 : (bt ? 4 : 2);
        sb.push_back(e);
        @(negedge clk);
        drive(ld, bt, p, u, w, b, o, sd);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = poke;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
        check("busy_after_accept", {31'b0, bus.busy}, 1);
        lat = 1;
        while (!bus.done && lat < 12) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("busy_at_done", {31'b0, bus.busy}, 0);
        check("loadData", bus.loadData, e.loadData);
        check("wbAddr", bus.wbAddr, e.wbAddr);
        check("wbEn", {31'b0, bus.wbEn}, {31'b0, e.wbEn});
        check("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
        repeat (poke ? 4 : 1) begin
            @(posedge clk);
            #1;
            check("no_extra_done", {30'b0, bus.done, bus.busy}, 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        lastLoad = '0;
        for (int i = 0; i < 256; i++) refMem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        clearMem = 1'b0;
        check("rst_memEn", {31'b0, bus.memoryEnable}, 0);
        check("rst_rnw", {31'b0, bus.readNotWrite}, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_outs", {bus.done, bus.busy, bus.wbEn, bus.misaligned, bus.memoryEnable}, 0);
        check("rst_loadData", bus.loadData, 0);
        check("rst_wbAddr", bus.wbAddr, 0);
        check("rst_memAddr", bus.memAddr, 0);

        request(0, 0, 1, 1, 0, 32'h20, 32'h4, 32'hDEADBEEF, 0);
        request(1, 0, 1, 1, 0, 32'h24, 32'h0, 32'h0, 0);
        request(0, 0, 1, 1, 0, 32'h24, 32'h0, 32'h11223344, 0);
        request(0, 1, 1, 1, 1, 32'h20, 32'h5, 32'hFFFFFF5A, 0);
        request(1, 0, 1, 1, 0, 32'h24, 32'h0, 32'h0, 0);
        check("strb_merged", lastLoad, 32'h11225A44);
        request(1, 1, 1, 0, 0, 32'h26, 32'h1, 32'h0, 0);
        request(1, 1, 0, 1, 1, 32'h27, 32'h10, 32'h0, 0);
        request(0, 0, 1, 1, 0, 32'h28, 32'h0, 32'hCAFEF00D, 0);
        request(1, 0, 1, 1, 0, 32'h2A, 32'h0, 32'h0, 0);
        request(0, 0, 1, 1, 0, 32'h40, 32'h0, 32'h13579BDF, 0);
        request(1, 0, 0, 0, 0, 32'h40, 32'h8, 32'h0, 0);
        request(0, 0, 1, 1, 0, 32'h400, 32'h4, 32'hA5A50404, 0);
        request(1, 0, 1, 1, 0, 32'h0, 32'h4, 32'h0, 0);
        request(1, 0, 1, 1, 0, 32'h20, 32'h4, 32'h0, 1);
        request(0, 0, 1, 0, 0, 32'h30, 32'h4, 32'h0BADF00D, 1);

        // STRB aborted by reset while in WRITE
        @(negedge clk);
        drive(0, 1, 1, 1, 0, 32'h24, 32'h0, 32'h00000077);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("strb_in_write", {30'b0, bus.memoryEnable, bus.readNotWrite}, 32'b10);
        reset = 1'b1;
        #1;
        check("rst_blocks_write", {30'b0, bus.memoryEnable, bus.readNotWrite}, 32'b01);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lastLoad = '0;
        check("abort_mem", mem[9], refMem[9]);
        check("abort_outs", {bus.done, bus.busy, bus.wbEn, bus.misaligned}, 0);
        check("abort_loadData", bus.loadData, 0);
        check("abort_wbAddr", bus.wbAddr, 0);
        request(1, 0, 1, 1, 0, 32'h24, 32'h0, 32'h0, 0);

        for (int i = 0; i < 16; i++)
            request(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    32'($urandom_range(0, 64)), $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 256; i++) check("mem_final", mem[i], refMem[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
